rv32im_div_unit: RTL and testbench
==================================

RV32IM_DIV_UNIT -- requirements
Module: rv32im_div_unit

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; SHALL be even and >= 4.
REQ-002 Parameter BPC, 1, quotient bits retired per iteration; legal values 1 or 2; WIDTH SHALL be a multiple of BPC.
REQ-003 Port clk_i  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 Port rst_ni  input  1  synchronous active-low reset, sampled on rising edge of clk_i.
REQ-005 Port start_i  input  1  request a new operation; accepted only when busy_o=0.
REQ-006 Port op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
REQ-007 Port abort_i  input  1  pipeline flush; kills any operation in progress.
REQ-008 Port a_i  input  WIDTH  dividend; sampled with start_i.
REQ-009 Port b_i  input  WIDTH  divisor; sampled with start_i.
REQ-010 Port busy_o  output  1  operation in progress; new start_i ignored.
REQ-011 Port valid_o  output  1  one-cycle pulse; result_o/dbz_o/ovf_o valid.
REQ-012 Port result_o  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-013 Port dbz_o  output  1  divisor was zero; qualified by valid_o.
REQ-014 Port ovf_o  output  1  signed overflow (DIV/REM, a=most-negative, b=-1); qualified by valid_o.

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIXUP, DONE; DONE lasts exactly one cycle and returns to IDLE.
REQ-016 IDLE: start_i=1 and abort_i=0 accepts operands; b_i=0 or signed overflow -> DONE; else -> CALC with iteration counter 0.
REQ-017 busy_o SHALL be 1 in CALC and FIXUP, 0 in IDLE and DONE; start_i in DONE SHALL be accepted as in IDLE.
REQ-018 start_i while busy_o=1 SHALL be ignored, with no effect on operands or state.
REQ-019 Signed ops (DIV, REM) SHALL divide magnitudes |a|,|b| unsigned; unsigned ops use operands as-is.
REQ-020 CALC SHALL perform restoring division, BPC quotient bits per cycle, accumulator WIDTH+1 bits; exactly WIDTH/BPC cycles, then -> FIXUP.
REQ-021 FIXUP SHALL negate quotient when signed op and sign(a)!=sign(b); negate remainder when signed op and a negative; select quotient/remainder by op_i; -> DONE.
REQ-022 Normal latency: valid_o=1 exactly WIDTH/BPC+2 cycles after the accepting edge (34 for WIDTH=32, BPC=1; 18 for BPC=2).
REQ-023 Special-case latency: valid_o=1 exactly 1 cycle after the accepting edge.
REQ-024 Divide by zero: quotient all ones, remainder = a (all four ops); dbz_o=1, ovf_o=0.
REQ-025 Signed overflow: quotient = a (most negative), remainder 0; ovf_o=1, dbz_o=0.
REQ-026 result_o, dbz_o, ovf_o SHALL hold their values from the valid_o pulse until the next valid_o pulse or reset.
REQ-027 abort_i=1 in any state SHALL force IDLE on next edge, suppress valid_o, leave result_o/dbz_o/ovf_o unchanged; abort_i wins over simultaneous start_i.
REQ-028 Zero dividend, b!=0 SHALL yield quotient 0, remainder 0 with normal latency (no early-out).

Reset
REQ-029 rst_ni=0 at a rising edge SHALL force IDLE, busy_o=0, valid_o=0, dbz_o=0, ovf_o=0, result_o=0, counter 0, regardless of state or start_i.
REQ-030 Reset mid-CALC SHALL discard the operation; no valid_o until a new start_i after rst_ni=1.

Verification
REQ-031 DIVU a=100, b=7 (WIDTH=32, BPC=1) -> valid_o 34 cycles after start, result_o=14; repeat REMU -> 2.
REQ-032 DIV a=-100, b=7 -> -14 (0xFFFFFFF2); REM a=-100, b=7 -> -2 (0xFFFFFFFE); REM a=100, b=-7 -> 2.
REQ-033 DIV a=5, b=0 -> valid_o after 1 cycle, result 0xFFFFFFFF, dbz_o=1; REMU a=5, b=0 -> 5, dbz_o=1.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> after 1 cycle result 0x80000000, ovf_o=1; REM same -> 0, ovf_o=1.
REQ-035 Start DIVU 100/7, abort_i at cycle 10 with start_i asserted -> no valid_o, busy_o=0 next cycle; fresh start then completes normally.
REQ-036 BPC=2 build: random signed/unsigned sweep (incl. 0, 1, -1, max, min) against reference model; every valid_o exactly 18 cycles after start; start_i during busy_o ignored.

Source files
------------

// File: rtl/rv32im_div_unit.sv
// rtl/rv32im_div_unit.sv - iterative RV32M divide/remainder unit
// Restoring division over operand magnitudes, BPC quotient bits per cycle, sign fixup at the end.
module rv32im_div_unit #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  localparam int ITERS = WIDTH / BPC;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rem_sel_q, rem_sel_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             signed_op, a_neg, b_neg, b_zero, ovf_case, accept;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH-1:0] step_quo, step_rem;
  logic [WIDTH:0]   acc, trial;

  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & a_i[WIDTH-1];
    b_neg     = signed_op & b_i[WIDTH-1];
    a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
    b_zero    = (b_i == '0);
    ovf_case  = signed_op & (a_i == MOST_NEG) & (&b_i);
    accept    = ((state_q == IDLE) || (state_q == DONE)) & start_i & ~abort_i;
    quo_fix   = qneg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix   = rneg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Partial remainder stays below the divisor, so WIDTH bits hold it between steps;
  // the shifted trial value needs WIDTH+1.
  always_comb begin
    step_quo = quo_q;
    step_rem = rem_q;
    acc      = '0;
    trial    = '0;
    for (int i = 0; i < BPC; i++) begin
      acc      = {step_rem, step_quo[WIDTH-1]};
      trial    = acc - {1'b0, dvs_q};
      step_quo = {step_quo[WIDTH-2:0], ~trial[WIDTH]};
      step_rem = trial[WIDTH] ? acc[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          rem_sel_d = op_i[1];
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          if (b_zero) begin
            result_d = op_i[1] ? a_i : '1;
            dbz_d    = 1'b1;
            ovf_d    = 1'b0;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else if (ovf_case) begin
            result_d = op_i[1] ? '0 : a_i;
            dbz_d    = 1'b0;
            ovf_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) begin
          cnt_d   = '0;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        result_d = rem_sel_q ? rem_fix : quo_fix;
        dbz_d    = 1'b0;
        ovf_d    = 1'b0;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A flush leaves the last delivered result visible.
    if (abort_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      valid_d  = 1'b0;
      result_d = result_q;
      dbz_d    = dbz_q;
      ovf_d    = ovf_q;
    end

    busy_d = (state_d == CALC) || (state_d == FIXUP);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign dbz_o    = dbz_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_rv32im_div_unit.sv
// tb/tb_rv32im_div_unit.sv - directed and sweep checks for rv32im_div_unit
// Two instances: BPC=1 for directed vectors, BPC=2 for the reference-model sweep.
module tb_rv32im_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, valid, dbz, ovf;
  logic [31:0] result;

  logic        s2_start = 1'b0;
  logic [1:0]  s2_op = 2'd0;
  logic [31:0] s2_a = '0, s2_b = '0;
  logic        s2_busy, s2_valid, s2_dbz, s2_ovf;
  logic [31:0] s2_result;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  rv32im_div_unit #(.WIDTH(32), .BPC(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .abort_i(abort),
    .a_i(a), .b_i(b), .busy_o(busy), .valid_o(valid), .result_o(result),
    .dbz_o(dbz), .ovf_o(ovf)
  );

  rv32im_div_unit #(.WIDTH(32), .BPC(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s2_start), .op_i(s2_op), .abort_i(1'b0),
    .a_i(s2_a), .b_i(s2_b), .busy_o(s2_busy), .valid_o(s2_valid), .result_o(s2_result),
    .dbz_o(s2_dbz), .ovf_o(s2_ovf)
  );

  // Called at a negedge; returns at the negedge where valid is seen (lat = cycles after accept).
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] r, output logic d, output logic ov);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; r = '0; d = 1'b0; ov = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (valid) begin
        lat = n; r = result; d = dbz; ov = ovf;
        break;
      end
    end
  endtask

  task automatic do_op2(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int glitch_at, output int lat, output logic [31:0] r,
                        output logic d, output logic ov);
    s2_start = 1'b1; s2_op = o; s2_a = x; s2_b = y;
    @(posedge clk); #1;
    s2_start = 1'b0;
    lat = -1; r = '0; d = 1'b0; ov = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      s2_start = (n == glitch_at);
      if (n == glitch_at) begin
        s2_op = 2'd2; s2_a = 32'd1; s2_b = 32'd0;
      end
      if (s2_valid) begin
        lat = n; r = s2_result; d = s2_dbz; ov = s2_ovf;
        break;
      end
    end
    s2_start = 1'b0;
  endtask

  function automatic void ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic d, output logic ov,
                                  output int lat);
    d = 1'b0; ov = 1'b0; lat = 18;
    if (y == 32'd0) begin
      d = 1'b1; lat = 1;
      r = o[1] ? x : 32'hFFFFFFFF;
    end else if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
      ov = 1'b1; lat = 1;
      r = o[1] ? 32'd0 : x;
    end else begin
      case (o)
        2'd0:    r = 32'($signed(x) / $signed(y));
        2'd1:    r = x / y;
        2'd2:    r = 32'($signed(x) % $signed(y));
        default: r = x % y;
      endcase
    end
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid); end
    vecs++; if (result !== 32'd0) begin errs++; $display("FAIL reset_result: got %h want 0", result); end
    vecs++; if (dbz !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL reset_flags: got dbz=%b ovf=%b want 0 0", dbz, ovf); end
    vecs++; if (s2_busy !== 1'b0 || s2_valid !== 1'b0) begin errs++; $display("FAIL reset_dut2: got busy=%b valid=%b want 0 0", s2_busy, s2_valid); end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_remu;
    int lat; logic [31:0] r; logic d, ov;
    do_op(2'd1, 32'd100, 32'd7, lat, r, d, ov);
    vecs++; if (lat !== 34) begin errs++; $display("FAIL divu_latency: got %0d want 34", lat); end
    vecs++; if (r !== 32'd14) begin errs++; $display("FAIL divu_result: got %h want 0000000e", r); end
    vecs++; if (d !== 1'b0 || ov !== 1'b0) begin errs++; $display("FAIL divu_flags: got dbz=%b ovf=%b want 0 0", d, ov); end
    repeat (2) @(negedge clk);
    do_op(2'd3, 32'd100, 32'd7, lat, r, d, ov);
    vecs++; if (lat !== 34) begin errs++; $display("FAIL remu_latency: got %0d want 34", lat); end
    vecs++; if (r !== 32'd2) begin errs++; $display("FAIL remu_result: got %h want 00000002", r); end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] r; logic d, ov;
    vec_t t [8];
    t = '{'{2'd0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2},
          '{2'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE},
          '{2'd2, 32'd100,      32'hFFFFFFF9, 32'd2},
          '{2'd0, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2},
          '{2'd0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14},
          '{2'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE},
          '{2'd1, 32'hFFFFFF9C, 32'd7,        32'h24924916},
          '{2'd3, 32'hFFFFFF9C, 32'd7,        32'd2}};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      do_op(t[i].op, t[i].a, t[i].b, lat, r, d, ov);
      vecs++; if (lat !== 34 || r !== t[i].exp) begin
        errs++; $display("FAIL signed_vec%0d: got lat=%0d res=%h want lat=34 res=%h", i, lat, r, t[i].exp);
      end
    end
  endtask

  task automatic test_dbz;
    int lat; logic [31:0] r; logic d, ov;
    vec_t t [4];
    t = '{'{2'd0, 32'd5,        32'd0, 32'hFFFFFFFF},
          '{2'd3, 32'd5,        32'd0, 32'd5},
          '{2'd1, 32'd5,        32'd0, 32'hFFFFFFFF},
          '{2'd2, 32'hFFFFFFFD, 32'd0, 32'hFFFFFFFD}};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      do_op(t[i].op, t[i].a, t[i].b, lat, r, d, ov);
      vecs++; if (lat !== 1) begin errs++; $display("FAIL dbz_latency%0d: got %0d want 1", i, lat); end
      vecs++; if (r !== t[i].exp || d !== 1'b1 || ov !== 1'b0) begin
        errs++; $display("FAIL dbz_vec%0d: got res=%h dbz=%b ovf=%b want res=%h dbz=1 ovf=0", i, r, d, ov, t[i].exp);
      end
    end
  endtask

  task automatic test_ovf;
    int lat; logic [31:0] r; logic d, ov;
    @(negedge clk);
    do_op(2'd0, 32'h80000000, 32'hFFFFFFFF, lat, r, d, ov);
    vecs++; if (lat !== 1 || r !== 32'h80000000 || ov !== 1'b1 || d !== 1'b0) begin
      errs++; $display("FAIL ovf_div: got lat=%0d res=%h ovf=%b dbz=%b want 1 80000000 1 0", lat, r, ov, d);
    end
    @(negedge clk);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, lat, r, d, ov);
    vecs++; if (lat !== 1 || r !== 32'd0 || ov !== 1'b1 || d !== 1'b0) begin
      errs++; $display("FAIL ovf_rem: got lat=%0d res=%h ovf=%b dbz=%b want 1 00000000 1 0", lat, r, ov, d);
    end
    @(negedge clk);
    do_op(2'd1, 32'h80000000, 32'hFFFFFFFF, lat, r, d, ov);
    vecs++; if (lat !== 34 || r !== 32'd0 || ov !== 1'b0) begin
      errs++; $display("FAIL ovf_divu_none: got lat=%0d res=%h ovf=%b want 34 00000000 0", lat, r, ov);
    end
  endtask

  task automatic test_zero_dividend;
    int lat; logic [31:0] r; logic d, ov;
    @(negedge clk);
    do_op(2'd0, 32'd0, 32'd9, lat, r, d, ov);
    vecs++; if (lat !== 34 || r !== 32'd0) begin errs++; $display("FAIL zero_div: got lat=%0d res=%h want 34 00000000", lat, r); end
    @(negedge clk);
    do_op(2'd2, 32'd0, 32'hFFFFFFF7, lat, r, d, ov);
    vecs++; if (lat !== 34 || r !== 32'd0) begin errs++; $display("FAIL zero_rem: got lat=%0d res=%h want 34 00000000", lat, r); end
  endtask

  task automatic test_hold;
    int lat; logic [31:0] r; logic d, ov;
    @(negedge clk);
    do_op(2'd3, 32'd100, 32'd7, lat, r, d, ov);
    repeat (5) @(negedge clk);
    vecs++; if (valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL hold_pulse: got valid=%b busy=%b want 0 0", valid, busy); end
    vecs++; if (result !== 32'd2 || dbz !== 1'b0 || ovf !== 1'b0) begin
      errs++; $display("FAIL hold_result: got res=%h dbz=%b ovf=%b want 00000002 0 0", result, dbz, ovf);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] r; logic d, ov;
    @(negedge clk);
    do_op(2'd1, 32'd100, 32'd7, lat, r, d, ov);
    do_op(2'd3, 32'd100, 32'd7, lat, r, d, ov);
    vecs++; if (lat !== 34 || r !== 32'd2) begin errs++; $display("FAIL b2b_normal: got lat=%0d res=%h want 34 00000002", lat, r); end
    do_op(2'd0, 32'd5, 32'd0, lat, r, d, ov);
    do_op(2'd1, 32'd100, 32'd7, lat, r, d, ov);
    vecs++; if (lat !== 34 || r !== 32'd14 || d !== 1'b0) begin
      errs++; $display("FAIL b2b_after_dbz: got lat=%0d res=%h dbz=%b want 34 0000000e 0", lat, r, d);
    end
  endtask

  task automatic test_busy_ignore;
    int lat; logic busy_seen;
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_seen = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = (n == 5);
      if (n == 5) begin
        busy_seen = busy; op = 2'd0; a = 32'd1; b = 32'd0;
      end
      if (valid) begin lat = n; break; end
    end
    start = 1'b0;
    vecs++; if (busy_seen !== 1'b1) begin errs++; $display("FAIL ignore_busy: got %b want 1", busy_seen); end
    vecs++; if (lat !== 34 || result !== 32'd14 || dbz !== 1'b0) begin
      errs++; $display("FAIL ignore_result: got lat=%0d res=%h dbz=%b want 34 0000000e 0", lat, result, dbz);
    end
  endtask

  task automatic test_abort;
    int lat; logic [31:0] r; logic d, ov; logic seen;
    @(negedge clk);
    do_op(2'd1, 32'd50, 32'd5, lat, r, d, ov);
    vecs++; if (r !== 32'd10) begin errs++; $display("FAIL abort_setup: got %h want 0000000a", r); end
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1; start = 1'b1; a = 32'd3; b = 32'd1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    vecs++; if (busy !== 1'b0 || valid !== 1'b0) begin errs++; $display("FAIL abort_idle: got busy=%b valid=%b want 0 0", busy, valid); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid) seen = 1'b1; end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL abort_suppress: got valid seen=%b want 0", seen); end
    vecs++; if (result !== 32'd10) begin errs++; $display("FAIL abort_hold: got %h want 0000000a", result); end
    do_op(2'd1, 32'd100, 32'd7, lat, r, d, ov);
    vecs++; if (lat !== 34 || r !== 32'd14) begin errs++; $display("FAIL abort_restart: got lat=%0d res=%h want 34 0000000e", lat, r); end
  endtask

  task automatic test_reset_midcalc;
    logic seen;
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vecs++; if (busy !== 1'b0 || result !== 32'd0) begin errs++; $display("FAIL midreset_state: got busy=%b res=%h want 0 00000000", busy, result); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid) seen = 1'b1; end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL midreset_valid: got valid seen=%b want 0", seen); end
  endtask

  task automatic test_bpc2_sweep;
    int lat, elat; logic [31:0] r, er; logic d, ov, ed, eov;
    logic [31:0] pool [7];
    logic [31:0] x, y;
    pool = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'd7, 32'hFFFFFF9C};
    @(negedge clk);
    for (int i = 0; i < 7 * 7 * 4 + 24; i++) begin
      if (i < 196) begin
        x = pool[i / 28]; y = pool[(i / 4) % 7];
      end else begin
        x = $urandom; y = $urandom >> $urandom_range(0, 31);
      end
      ref_div(2'(i % 4), x, y, er, ed, eov, elat);
      do_op2(2'(i % 4), x, y, (i == 50) ? 4 : 0, lat, r, d, ov);
      vecs++; if (lat !== elat || r !== er || d !== ed || ov !== eov) begin
        errs++;
        $display("FAIL bpc2_vec%0d op=%0d a=%h b=%h: got lat=%0d res=%h dbz=%b ovf=%b want lat=%0d res=%h dbz=%b ovf=%b",
                 i, i % 4, x, y, lat, r, d, ov, elat, er, ed, eov);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_divu_remu();
    test_signed();
    test_dbz();
    test_ovf();
    test_zero_dividend();
    test_hold();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_reset_midcalc();
    test_bpc2_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
